// File: rtl/ahblite_pkg.sv
// rtl/ahblite_pkg.sv - shared AHB-Lite encodings, default-slave state type and SoC map constants
package ahblite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // Default SoC map: CODE, DATA, KEYBOARD, LCD in slave-index order
    localparam logic [31:0] SOC_CODE_BASE = 32'h0000_0000;
    localparam logic [31:0] SOC_DATA_BASE = 32'h2000_0000;
    localparam logic [31:0] SOC_KBD_BASE  = 32'h4000_0000;
    localparam logic [31:0] SOC_LCD_BASE  = 32'h4000_1000;
    localparam logic [31:0] SOC_MAP_MASK  = 32'hF000_F000;

endpackage

// File: rtl/ahblite_slave_mux_n_if.sv
// rtl/ahblite_slave_mux_n_if.sv - master-side and slave-side bus bundle of the N-port decoder/mux
interface ahblite_slave_mux_n_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [ADDR_W-1:0]            HADDR;
    logic [1:0]                   HTRANS;
    logic                         HREADY;
    logic [DATA_W-1:0]            HRDATA;
    logic                         HRESP;
    logic [NUM_SLAVES-1:0]        HSEL_S;
    logic [NUM_SLAVES-1:0]        HREADYOUT_S;
    logic [NUM_SLAVES-1:0]        HRESP_S;
    logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S;

    // slave: the decoder/mux view; master: the bus master plus slave ports around it
    modport slave (
        input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
        output HREADY, HRDATA, HRESP, HSEL_S
    );

    modport master (
        output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
        input  HREADY, HRDATA, HRESP, HSEL_S
    );
endinterface

// File: rtl/ahblite_default_slave.sv
// rtl/ahblite_default_slave.sv - two-cycle ERROR default slave with unmapped-access capture and IRQ
module ahblite_default_slave
    import ahblite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                hready,
    input  logic                unmapped_req,
    input  logic [ADDR_W-1:0]   haddr,
    input  logic                err_clr,
    output logic                ds_hready,
    output logic                ds_hresp,
    output logic                err_valid,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                err_irq
);

    localparam logic [ERRCNT_W-1:0] CNT_ONE = ERRCNT_W'(1);

    ds_state_e state, state_nxt;
    logic      start_err;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_OK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_err = 1'b0;
        case (state)
            DS_OK: begin
                if (hready && unmapped_req) begin
                    state_nxt = DS_ERR1;
                    start_err = 1'b1;
                end
            end
            DS_ERR1: begin
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                if (hready && unmapped_req) begin
                    state_nxt = DS_ERR1;
                    start_err = 1'b1;
                end else begin
                    state_nxt = DS_OK;
                end
            end
            default: begin
                state_nxt = DS_OK;
            end
        endcase
    end

    // Response depends on state only, so the HREADY feedback path stays acyclic
    assign ds_hready = (state != DS_ERR1);
    assign ds_hresp  = (state == DS_OK) ? HRESP_OKAY : HRESP_ERROR;
    assign err_irq   = (state == DS_ERR1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else if (start_err) begin
            err_valid <= 1'b1;
            err_addr  <= haddr;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ahblite_slave_mux_n.sv
// rtl/ahblite_slave_mux_n.sv - single-master AHB-Lite address decoder and response mux for N slaves
module ahblite_slave_mux_n
    import ahblite_pkg::*;
#(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDR  =
        {SOC_LCD_BASE, SOC_KBD_BASE, SOC_DATA_BASE, SOC_CODE_BASE},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASK  = {4{SOC_MAP_MASK}},
    parameter int                           ERRCNT_W   = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahblite_slave_mux_n_if.slave   bus,
    input  logic                   err_clr,
    output logic                   err_valid,
    output logic [ADDR_W-1:0]      err_addr,
    output logic [ERRCNT_W-1:0]    err_cnt,
    output logic                   err_irq
);

    localparam logic [NUM_SLAVES:0] DSEL_DEFAULT = {1'b1, {NUM_SLAVES{1'b0}}};

    logic [NUM_SLAVES-1:0] hit;
    logic                  found;
    logic                  active;
    logic [NUM_SLAVES:0]   dsel;
    logic                  hready_mux;
    logic                  hresp_mux;
    logic [DATA_W-1:0]     hrdata_mux;
    logic                  ds_hready;
    logic                  ds_hresp;

    // Lowest matching index wins on overlapping regions
    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found &&
                ((bus.HADDR & ADDR_MASK[i*ADDR_W +: ADDR_W]) == BASE_ADDR[i*ADDR_W +: ADDR_W])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign bus.HSEL_S = hit;
    assign active     = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= DSEL_DEFAULT;
        end else if (hready_mux) begin
            dsel <= {~found, hit};
        end
    end

    always_comb begin
        hready_mux = 1'b0;
        hresp_mux  = 1'b0;
        hrdata_mux = '0;
        if (dsel[NUM_SLAVES]) begin
            hready_mux = ds_hready;
            hresp_mux  = ds_hresp;
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                hready_mux = hready_mux | bus.HREADYOUT_S[i];
                hresp_mux  = hresp_mux  | bus.HRESP_S[i];
                hrdata_mux = hrdata_mux | bus.HRDATA_S[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.HREADY = hready_mux;
    assign bus.HRESP  = hresp_mux;
    assign bus.HRDATA = hrdata_mux;

    ahblite_default_slave #(
        .ADDR_W   (ADDR_W),
        .ERRCNT_W (ERRCNT_W)
    ) u_default_slave (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .hready       (hready_mux),
        .unmapped_req (active & ~found),
        .haddr        (bus.HADDR),
        .err_clr      (err_clr),
        .ds_hready    (ds_hready),
        .ds_hresp     (ds_hresp),
        .err_valid    (err_valid),
        .err_addr     (err_addr),
        .err_cnt      (err_cnt),
        .err_irq      (err_irq)
    );

endmodule

// File: tb/tb_ahblite_slave_mux_n.sv
// tb/tb_ahblite_slave_mux_n.sv - scoreboard bench for the N-port AHB-Lite decoder/mux
module tb_ahblite_slave_mux_n;
    import ahblite_pkg::*;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 2;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          err_clr;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic [EW-1:0] err_cnt;
    logic          err_irq;

    ahblite_slave_mux_n_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ahblite_slave_mux_n #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .BASE_ADDR  ({32'h4000_1000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
        .ADDR_MASK  ({4{32'hF000_F000}}),
        .ERRCNT_W   (EW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt),
        .err_irq   (err_irq)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [NS-1:0] hsel;
        logic [DW-1:0] data;
        logic          resp;
        logic [7:0]    waits;
        logic [7:0]    id;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   in_data = 1'b0;
    bit   tag = 1'b0;
    int   wcnt = 0;
    int   irq_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   next_id = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: completes data phases and accepts tagged address phases
    initial forever begin
        @(negedge HCLK);
        if (!HRESETn) begin
            in_data = 1'b0;
        end else begin
            if (err_irq) irq_cnt++;
            if (in_data) begin
                if (!bus.HREADY) begin
                    wcnt++;
                    chk($sformatf("wait_resp#%0d", cur.id), 64'(bus.HRESP), 64'(cur.resp));
                end else begin
                    chk($sformatf("rdata#%0d", cur.id), 64'(bus.HRDATA), 64'(cur.data));
                    chk($sformatf("resp#%0d", cur.id), 64'(bus.HRESP), 64'(cur.resp));
                    chk($sformatf("waits#%0d", cur.id), 64'(wcnt), 64'(cur.waits));
                    in_data = 1'b0;
                end
            end
            if (bus.HREADY && tag) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL underflow actual=empty required=item");
                end else begin
                    cur = exp_q.pop_front();
                    chk($sformatf("hsel#%0d", cur.id), 64'(bus.HSEL_S), 64'(cur.hsel));
                    in_data = 1'b1;
                    wcnt    = 0;
                end
            end
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic [1:0] tr, input logic [NS-1:0] hsel,
                         input logic [DW-1:0] d, input logic r, input int w);
        exp_t e;
        bit   acc;
        e.hsel  = hsel;
        e.data  = d;
        e.resp  = r;
        e.waits = 8'(w);
        e.id    = 8'(next_id);
        next_id++;
        exp_q.push_back(e);
        bus.HADDR  = a;
        bus.HTRANS = tr;
        tag        = 1'b1;
        acc        = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge HCLK);
            acc = bus.HREADY;
            @(posedge HCLK);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted addr=%0h", a);
        end
        #1;
    endtask

    task automatic idle();
        bus.HTRANS = HTRANS_IDLE;
        tag        = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        HRESETn = 1'b0;
        cycles(2);
        HRESETn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.HADDR       = '0;
        bus.HTRANS      = HTRANS_IDLE;
        bus.HREADYOUT_S = '1;
        bus.HRESP_S     = '0;
        for (int i = 0; i < NS; i++) bus.HRDATA_S[i*DW +: DW] = 32'hCAFE_0000 | i;
        err_clr = 1'b0;

        #12;
        chk("rst_hready", 64'(bus.HREADY), 64'd1);
        chk("rst_hresp", 64'(bus.HRESP), 64'd0);
        chk("rst_hrdata", 64'(bus.HRDATA), 64'd0);
        chk("rst_hsel_addr0", 64'(bus.HSEL_S), 64'b0001);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_err_irq", 64'(err_irq), 64'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cycles(1);

        // mapped read of slave1
        issue(32'h2000_0010, HTRANS_NONSEQ, 4'b0010, 32'hCAFE_0001, 1'b0, 0);
        idle();
        cycles(2);

        // slave3 stalls 3 cycles while the next address targets slave0
        issue(32'h4000_1004, HTRANS_NONSEQ, 4'b1000, 32'hCAFE_0003, 1'b0, 3);
        bus.HREADYOUT_S[3] = 1'b0;
        fork
            begin
                repeat (3) @(posedge HCLK);
                #1;
                bus.HREADYOUT_S[3] = 1'b1;
            end
        join_none
        issue(32'h0000_0040, HTRANS_NONSEQ, 4'b0001, 32'hCAFE_0000, 1'b0, 0);
        issue(32'h2000_0044, HTRANS_SEQ, 4'b0010, 32'hCAFE_0001, 1'b0, 0);
        idle();
        cycles(2);

        // single unmapped write
        issue(32'h8000_0004, HTRANS_NONSEQ, 4'b0000, 32'h0, 1'b1, 1);
        idle();
        cycles(3);
        chk("e1_valid", 64'(err_valid), 64'd1);
        chk("e1_addr", 64'(err_addr), 64'h8000_0004);
        chk("e1_cnt", 64'(err_cnt), 64'd1);
        chk("e1_irqs", 64'(irq_cnt), 64'd1);

        do_reset();
        chk("rst2_cnt", 64'(err_cnt), 64'd0);

        // back-to-back unmapped
        issue(32'h8000_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, 1'b1, 1);
        issue(32'h9000_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, 1'b1, 1);
        idle();
        cycles(3);
        chk("b2b_cnt", 64'(err_cnt), 64'd2);
        chk("b2b_addr", 64'(err_addr), 64'h9000_0000);
        chk("b2b_irqs", 64'(irq_cnt), 64'd3);

        // IDLE to unmapped: zero-wait OKAY, no error
        issue(32'h8000_0000, HTRANS_IDLE, 4'b0000, 32'h0, 1'b0, 0);
        idle();
        cycles(2);
        chk("idle_irqs", 64'(irq_cnt), 64'd3);
        chk("idle_cnt", 64'(err_cnt), 64'd2);

        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk("clr_valid", 64'(err_valid), 64'd0);
        chk("clr_addr_kept", 64'(err_addr), 64'h9000_0000);
        chk("clr_cnt_kept", 64'(err_cnt), 64'd2);

        // clear coincides with a new error: new error wins
        err_clr = 1'b1;
        issue(32'hA000_0008, HTRANS_NONSEQ, 4'b0000, 32'h0, 1'b1, 1);
        err_clr = 1'b0;
        idle();
        cycles(3);
        chk("coin_valid", 64'(err_valid), 64'd1);
        chk("coin_addr", 64'(err_addr), 64'hA000_0008);
        chk("coin_cnt", 64'(err_cnt), 64'd3);

        // two more errors: counter saturates
        issue(32'hB000_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, 1'b1, 1);
        issue(32'hC000_0000, HTRANS_NONSEQ, 4'b0000, 32'h0, 1'b1, 1);
        idle();
        cycles(3);
        chk("sat_cnt", 64'(err_cnt), 64'd3);
        chk("sat_addr", 64'(err_addr), 64'hC000_0000);
        chk("sat_irqs", 64'(irq_cnt), 64'd6);

        // async reset in the middle of DS_ERR1
        bus.HADDR  = 32'hD000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        tag        = 1'b0;
        cycles(1);
        chk("err1_hready", 64'(bus.HREADY), 64'd0);
        chk("err1_hresp", 64'(bus.HRESP), 64'd1);
        chk("err1_irq", 64'(err_irq), 64'd1);
        HRESETn = 1'b0;
        #1;
        chk("arst_hready", 64'(bus.HREADY), 64'd1);
        chk("arst_hresp", 64'(bus.HRESP), 64'd0);
        chk("arst_hrdata", 64'(bus.HRDATA), 64'd0);
        chk("arst_valid", 64'(err_valid), 64'd0);
        chk("arst_addr", 64'(err_addr), 64'd0);
        chk("arst_cnt", 64'(err_cnt), 64'd0);
        chk("arst_irq", 64'(err_irq), 64'd0);
        idle();
        cycles(1);
        HRESETn = 1'b1;
        cycles(1);
        issue(32'h2000_0020, HTRANS_NONSEQ, 4'b0010, 32'hCAFE_0001, 1'b0, 0);
        idle();
        cycles(3);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("no_open_phase", 64'(in_data), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
